// File: rtl/sys_cmd_pkg.sv
// Command-link definitions shared by the host-side master and the responder-side controller.
package sys_cmd_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CT_REG_WR  = 2'd0,
        CT_REG_RD  = 2'd1,
        CT_ALU_OP  = 2'd2,
        CT_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_e;

    // Index of the final byte of a frame (frames are 2 to 4 bytes long).
    function automatic logic [1:0] frame_last_idx(input cmd_type_e t);
        case (t)
            CT_REG_WR: return 2'd2;
            CT_REG_RD: return 2'd1;
            CT_ALU_OP: return 2'd3;
            default:   return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/rsp_watchdog.sv
// Saturating cycle counter that flags expiry once it has counted LIMIT-1 enabled cycles.
module rsp_watchdog #(
    parameter int LIMIT = 4096
) (
    input  logic CLK_IN,
    input  logic RST_IN,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_reg;

    assign expire = (cnt_reg == CW'(LIMIT - 1));

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && !expire) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/host_cmd_master.sv
// Host-side command link master: serialises one command into an AA/BB/CC/DD UART frame
// and collects the 0-2 byte response, bounded by a response watchdog.
module host_cmd_master
    import sys_cmd_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int RSP_W       = 2 * WIDTH,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             CLK_IN,
    input  logic             RST_IN,
    input  logic             CMD_VLD,
    output logic             CMD_RDY,
    input  logic [1:0]       CMD_TYPE,
    input  logic [3:0]       CMD_ADDR,
    input  logic [WIDTH-1:0] CMD_WDATA,
    input  logic [WIDTH-1:0] CMD_OPA,
    input  logic [WIDTH-1:0] CMD_OPB,
    input  logic [3:0]       CMD_FUNC,
    output logic [WIDTH-1:0] TX_P_DATA,
    output logic             TX_D_VLD,
    input  logic             TX_BUSY,
    input  logic [WIDTH-1:0] RX_P_DATA,
    input  logic             RX_D_VLD,
    input  logic             RX_ERR,
    output logic [RSP_W-1:0] RSP_DATA,
    output logic             RSP_VLD,
    output logic             RSP_ERR,
    output logic             RSP_TIMEOUT
);

    state_e           state_reg, state_next;
    cmd_type_e        type_reg;
    logic [3:0]       addr_reg, func_reg;
    logic [WIDTH-1:0] wdata_reg, opa_reg, opb_reg;
    logic [1:0]       idx_reg;
    logic             rx_cnt_reg, err_reg, tmo_reg;
    logic [WIDTH-1:0] tx_byte;
    logic [2*WIDTH-1:0] rsp_word;
    logic             accept, take, rx_in, rx_last, wd_clr, wd_expire;

    assign accept  = CMD_RDY & CMD_VLD;
    assign take    = TX_D_VLD & ~TX_BUSY;
    assign rx_in   = (state_reg == WAIT_RSP) & RX_D_VLD;
    assign rx_last = (type_reg == CT_REG_RD) | rx_cnt_reg;
    // Any received byte restarts the response window.
    assign wd_clr  = (state_reg != WAIT_RSP) | RX_D_VLD;

    rsp_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
        .CLK_IN (CLK_IN),
        .RST_IN (RST_IN),
        .clr    (wd_clr),
        .en     (state_reg == WAIT_RSP),
        .expire (wd_expire)
    );

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        CMD_RDY    = 1'b0;
        TX_D_VLD   = 1'b0;
        RSP_VLD    = 1'b0;
        case (state_reg)
            IDLE: begin
                CMD_RDY = 1'b1;
                if (CMD_VLD) state_next = SEND;
            end
            SEND: begin
                TX_D_VLD = 1'b1;
                if (!TX_BUSY && idx_reg == frame_last_idx(type_reg))
                    state_next = (type_reg == CT_REG_WR) ? DONE : WAIT_RSP;
            end
            WAIT_RSP: begin
                // A byte arriving on the expiry cycle takes priority over the timeout.
                if (RX_D_VLD) begin
                    if (RX_ERR || rx_last) state_next = DONE;
                end else if (wd_expire) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                RSP_VLD    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_byte = '0;
        case (type_reg)
            CT_REG_WR: case (idx_reg)
                2'd0:    tx_byte = WIDTH'(CMD_WR);
                2'd1:    tx_byte = WIDTH'(addr_reg);
                default: tx_byte = wdata_reg;
            endcase
            CT_REG_RD: tx_byte = (idx_reg == 2'd0) ? WIDTH'(CMD_RD) : WIDTH'(addr_reg);
            CT_ALU_OP: case (idx_reg)
                2'd0:    tx_byte = WIDTH'(CMD_ALU_OP);
                2'd1:    tx_byte = opa_reg;
                2'd2:    tx_byte = opb_reg;
                default: tx_byte = WIDTH'(func_reg);
            endcase
            default:   tx_byte = (idx_reg == 2'd0) ? WIDTH'(CMD_ALU_NOP) : WIDTH'(func_reg);
        endcase
        TX_P_DATA   = TX_D_VLD ? tx_byte : '0;
        RSP_ERR     = RSP_VLD & err_reg;
        RSP_TIMEOUT = RSP_VLD & tmo_reg;
        RSP_DATA    = RSP_W'(rsp_word);
    end

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            type_reg   <= CT_REG_WR;
            addr_reg   <= '0;
            func_reg   <= '0;
            wdata_reg  <= '0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            idx_reg    <= '0;
            rx_cnt_reg <= 1'b0;
            err_reg    <= 1'b0;
            tmo_reg    <= 1'b0;
        end else begin
            if (accept) begin
                type_reg   <= cmd_type_e'(CMD_TYPE);
                addr_reg   <= CMD_ADDR;
                func_reg   <= CMD_FUNC;
                wdata_reg  <= CMD_WDATA;
                opa_reg    <= CMD_OPA;
                opb_reg    <= CMD_OPB;
                idx_reg    <= '0;
                rx_cnt_reg <= 1'b0;
                err_reg    <= 1'b0;
                tmo_reg    <= 1'b0;
            end
            if (take) idx_reg <= idx_reg + 2'd1;
            if (rx_in) begin
                if (RX_ERR) err_reg    <= 1'b1;
                else        rx_cnt_reg <= 1'b1;
            end else if (state_reg == WAIT_RSP && wd_expire) begin
                tmo_reg <= 1'b1;
            end
        end
    end

    // Byte lane gi captures the gi-th good response byte; cleared on every accept.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp_lane
        logic [WIDTH-1:0] lane_reg;
        always_ff @(posedge CLK_IN or negedge RST_IN) begin
            if (!RST_IN)                                         lane_reg <= '0;
            else if (accept)                                     lane_reg <= '0;
            else if (rx_in && !RX_ERR && rx_cnt_reg == 1'(gi))   lane_reg <= RX_P_DATA;
        end
        assign rsp_word[gi*WIDTH +: WIDTH] = lane_reg;
    end

endmodule

// File: tb/tb_host_cmd_master.sv
// Randomised self-checking bench for host_cmd_master against a frame/response reference model.
`timescale 1ns/1ps
module tb_host_cmd_master;

    localparam int TO = 64;

    logic        CLK_IN = 1'b0, RST_IN = 1'b0;
    logic        CMD_VLD = 1'b0, CMD_RDY;
    logic [1:0]  CMD_TYPE = '0;
    logic [3:0]  CMD_ADDR = '0, CMD_FUNC = '0;
    logic [7:0]  CMD_WDATA = '0, CMD_OPA = '0, CMD_OPB = '0;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD, TX_BUSY = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0, RX_ERR = 1'b0;
    logic [15:0] RSP_DATA;
    logic        RSP_VLD, RSP_ERR, RSP_TIMEOUT;

    host_cmd_master #(.WIDTH(8), .RSP_W(16), .TIMEOUT_CYC(TO)) dut (
        .CLK_IN(CLK_IN), .RST_IN(RST_IN), .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY),
        .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_OPA(CMD_OPA),
        .CMD_OPB(CMD_OPB), .CMD_FUNC(CMD_FUNC), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .TX_BUSY(TX_BUSY), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
        .RSP_DATA(RSP_DATA), .RSP_VLD(RSP_VLD), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT)
    );

    always #5 CLK_IN = ~CLK_IN;

    typedef struct { logic [7:0] d; int cyc; } tx_rec_t;
    typedef struct { logic [15:0] d; logic err; logic tmo; int cyc; } rsp_rec_t;

    int       tests_run = 0, tests_failed = 0;
    int       cyc = 0, acc_cyc = 0, last_rx_cyc = 0, hold_viol = 0, qual_viol = 0;
    tx_rec_t  tx_log[$];
    rsp_rec_t rsp_log[$];
    logic     prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    always @(posedge CLK_IN) cyc <= cyc + 1;

    // Passive monitor, sampling mid-cycle.
    always @(negedge CLK_IN) begin
        tx_rec_t  tr;
        rsp_rec_t rr;
        if (!RST_IN) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!TX_D_VLD || TX_P_DATA !== prev_data)) hold_viol++;
            prev_stall = TX_D_VLD && TX_BUSY;
            prev_data  = TX_P_DATA;
        end
        if (TX_D_VLD && !TX_BUSY) begin tr.d = TX_P_DATA; tr.cyc = cyc; tx_log.push_back(tr); end
        if (RSP_VLD) begin
            rr.d = RSP_DATA; rr.err = RSP_ERR; rr.tmo = RSP_TIMEOUT; rr.cyc = cyc;
            rsp_log.push_back(rr);
        end
        if ((RSP_ERR || RSP_TIMEOUT) && !RSP_VLD) qual_viol++;
        if (RX_D_VLD) last_rx_cyc = cyc;
        if (CMD_VLD && CMD_RDY) acc_cyc = cyc;
    end

    // mode 0: full reply, 1: RX_ERR on reply byte k, 2: only k reply bytes then silence.
    task automatic do_txn(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] wd,
                          input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] fn,
                          input logic [7:0] rx0, input logic [7:0] rx1, input int busy_pct,
                          input int mode, input int k, input int hold_at, input bit spur);
        logic [7:0]  exp_q[$];
        logic [7:0]  rxb[2];
        logic [15:0] exp_data;
        int nrsp, nsend, n0, r0, budget, hold_n, c, ref_cyc, exp_cyc, md;
        bit timing_ok;
        rsp_rec_t rr;
        rxb[0] = rx0; rxb[1] = rx1;
        case (t)
            2'd0:    begin exp_q = '{8'hAA, {4'h0, ad}, wd};         nrsp = 0; end
            2'd1:    begin exp_q = '{8'hBB, {4'h0, ad}};             nrsp = 1; end
            2'd2:    begin exp_q = '{8'hCC, oa, ob, {4'h0, fn}};     nrsp = 2; end
            default: begin exp_q = '{8'hDD, {4'h0, fn}};             nrsp = 2; end
        endcase
        md    = (nrsp == 0) ? 0 : mode;
        nsend = (md == 0) ? nrsp : (md == 1) ? k + 1 : k;
        n0 = tx_log.size(); r0 = rsp_log.size();
        budget = 0;
        while (!CMD_RDY && budget < 50) begin @(posedge CLK_IN); #1; budget++; end
        tests_run++;
        if (CMD_RDY !== 1'b1) begin tests_failed++; $display("FAIL cmd_rdy_idle: got %b, want 1", CMD_RDY); end
        CMD_VLD = 1'b1; CMD_TYPE = t; CMD_ADDR = ad; CMD_WDATA = wd; CMD_OPA = oa; CMD_OPB = ob; CMD_FUNC = fn;
        @(posedge CLK_IN); #1;
        CMD_VLD = 1'b0; CMD_TYPE = 2'($urandom); CMD_ADDR = 4'($urandom); CMD_FUNC = 4'($urandom);
        CMD_WDATA = 8'($urandom); CMD_OPA = 8'($urandom); CMD_OPB = 8'($urandom);
        tests_run++;
        if (CMD_RDY !== 1'b0) begin tests_failed++; $display("FAIL cmd_rdy_busy: got %b, want 0", CMD_RDY); end
        budget = 0; hold_n = 0;
        while (tx_log.size() - n0 < exp_q.size() && budget < 500) begin
            if (tx_log.size() - n0 == hold_at && hold_n < 5) begin TX_BUSY = 1'b1; hold_n++; end
            else TX_BUSY = ($urandom_range(99) < busy_pct);
            RX_D_VLD = spur && ($urandom_range(2) == 0);
            RX_P_DATA = 8'($urandom); RX_ERR = 1'($urandom);
            @(posedge CLK_IN); #1; budget++;
        end
        TX_BUSY = 1'b0; RX_D_VLD = 1'b0; RX_ERR = 1'b0;
        tests_run++;
        if (tx_log.size() - n0 < exp_q.size()) begin
            tests_failed++;
            $display("FAIL tx_budget: %0d bytes taken, want %0d", tx_log.size() - n0, exp_q.size());
        end
        c = (tx_log.size() > n0) ? tx_log[tx_log.size()-1].cyc : cyc;
        exp_data = '0;
        for (int i = 0; i < nsend; i++) begin
            repeat ($urandom_range(3)) begin @(posedge CLK_IN); #1; end
            RX_D_VLD = 1'b1; RX_P_DATA = rxb[i]; RX_ERR = (md == 1 && i == k);
            if (!(md == 1 && i == k)) exp_data[8*i +: 8] = rxb[i];
            @(posedge CLK_IN); #1;
            RX_D_VLD = 1'b0; RX_ERR = 1'b0; RX_P_DATA = 8'($urandom);
        end
        budget = 0;
        while (rsp_log.size() == r0 && budget < TO + 40) begin @(posedge CLK_IN); #1; budget++; end
        repeat (3) begin @(posedge CLK_IN); #1; end
        tests_run++;
        if (tx_log.size() - n0 != exp_q.size()) begin
            tests_failed++;
            $display("FAIL tx_count: %0d bytes, want %0d", tx_log.size() - n0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (tx_log[n0+i].d !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL tx_byte%0d: got %h, want %h", i, tx_log[n0+i].d, exp_q[i]);
                end
            end
            if (busy_pct == 0 && hold_at < 0) begin
                timing_ok = 1'b1;
                for (int i = 0; i < exp_q.size(); i++)
                    if (tx_log[n0+i].cyc != acc_cyc + 1 + i) timing_ok = 1'b0;
                tests_run++;
                if (!timing_ok) begin
                    tests_failed++;
                    $display("FAIL tx_timing: first byte cycle %0d, want %0d, consecutive", tx_log[n0].cyc, acc_cyc + 1);
                end
            end
        end
        tests_run++;
        if (rsp_log.size() != r0 + 1) begin
            tests_failed++;
            $display("FAIL rsp_count: %0d RSP_VLD pulses, want 1", rsp_log.size() - r0);
        end else begin
            rr = rsp_log[r0];
            if (md == 2) begin
                ref_cyc = (last_rx_cyc > c) ? last_rx_cyc : c;
                exp_cyc = ref_cyc + TO + 1;
            end else begin
                exp_cyc = ((nrsp == 0) ? c : last_rx_cyc) + 1;
            end
            tests_run += 3;
            if (rr.err !== (md == 1)) begin tests_failed++; $display("FAIL rsp_err: got %b, want %b", rr.err, md == 1); end
            if (rr.tmo !== (md == 2)) begin tests_failed++; $display("FAIL rsp_timeout: got %b, want %b", rr.tmo, md == 2); end
            if (rr.cyc != exp_cyc) begin tests_failed++; $display("FAIL rsp_latency: cycle %0d, want %0d", rr.cyc, exp_cyc); end
            if (md != 1) begin
                tests_run++;
                if (rr.d !== exp_data) begin tests_failed++; $display("FAIL rsp_data: got %h, want %h", rr.d, exp_data); end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK_IN);
        tests_run += 6;
        if (CMD_RDY !== 1'b1)    begin tests_failed++; $display("FAIL reset_cmd_rdy: got %b, want 1", CMD_RDY); end
        if (TX_D_VLD !== 1'b0)   begin tests_failed++; $display("FAIL reset_tx_vld: got %b, want 0", TX_D_VLD); end
        if (TX_P_DATA !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %h, want 00", TX_P_DATA); end
        if (RSP_DATA !== 16'h0)  begin tests_failed++; $display("FAIL reset_rsp_data: got %h, want 0000", RSP_DATA); end
        if (RSP_VLD !== 1'b0)    begin tests_failed++; $display("FAIL reset_rsp_vld: got %b, want 0", RSP_VLD); end
        if ({RSP_ERR, RSP_TIMEOUT} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got %b, want 00", {RSP_ERR, RSP_TIMEOUT}); end
        @(posedge CLK_IN); #1; RST_IN = 1'b1;
        repeat (2) begin @(posedge CLK_IN); #1; end
    endtask

    task automatic test_reg_wr();
        do_txn(2'd0, 4'd5, 8'h3C, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 0, 0, 0, -1, 1'b0);
    endtask

    task automatic test_reg_rd();
        do_txn(2'd1, 4'd2, 8'h00, 8'h00, 8'h00, 4'd0, 8'h81, 8'h00, 0, 0, 0, -1, 1'b0);
    endtask

    task automatic test_alu_op();
        do_txn(2'd2, 4'd0, 8'h00, 8'h0F, 8'h03, 4'd2, 8'h2D, 8'h00, 0, 0, 0, -1, 1'b0);
    endtask

    task automatic test_busy_hold();
        do_txn(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd1, 8'h5A, 8'hA5, 0, 0, 0, 1, 1'b0);
        tests_run++;
        if (hold_viol != 0) begin tests_failed++; $display("FAIL tx_hold: %0d unstable stall cycles, want 0", hold_viol); end
    endtask

    task automatic test_timeout();
        int n0, r0, c, budget;
        do_txn(2'd1, 4'd7, 8'h00, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 0, 2, 0, -1, 1'b0);
        // Reply byte lands on the very cycle the window expires: the byte must win.
        n0 = tx_log.size(); r0 = rsp_log.size();
        CMD_VLD = 1'b1; CMD_TYPE = 2'd1; CMD_ADDR = 4'd9;
        @(posedge CLK_IN); #1; CMD_VLD = 1'b0;
        budget = 0;
        while (tx_log.size() - n0 < 2 && budget < 20) begin @(posedge CLK_IN); #1; budget++; end
        c = (tx_log.size() > n0) ? tx_log[tx_log.size()-1].cyc : cyc;
        while (cyc < c + TO) begin @(posedge CLK_IN); #1; end
        RX_D_VLD = 1'b1; RX_P_DATA = 8'hE7;
        @(posedge CLK_IN); #1; RX_D_VLD = 1'b0;
        repeat (3) begin @(posedge CLK_IN); #1; end
        tests_run++;
        if (rsp_log.size() != r0 + 1) begin
            tests_failed++;
            $display("FAIL edge_rsp_count: %0d pulses, want 1", rsp_log.size() - r0);
        end else begin
            tests_run += 2;
            if (rsp_log[r0].tmo !== 1'b0 || rsp_log[r0].cyc != c + TO + 1) begin
                tests_failed++;
                $display("FAIL edge_timeout: tmo=%b cycle %0d, want tmo=0 cycle %0d", rsp_log[r0].tmo, rsp_log[r0].cyc, c + TO + 1);
            end
            if (rsp_log[r0].d !== 16'h00E7) begin
                tests_failed++;
                $display("FAIL edge_data: got %h, want 00e7", rsp_log[r0].d);
            end
        end
    endtask

    task automatic test_rx_err_and_reset();
        int n0, r0;
        do_txn(2'd2, 4'd0, 8'h00, 8'h11, 8'h22, 4'd5, 8'h33, 8'h44, 0, 1, 0, -1, 1'b0);
        n0 = tx_log.size(); r0 = rsp_log.size();
        TX_BUSY = 1'b1; CMD_VLD = 1'b1; CMD_TYPE = 2'd2; CMD_OPA = 8'h77;
        @(posedge CLK_IN); #1; CMD_VLD = 1'b0;
        @(posedge CLK_IN); #2;
        RST_IN = 1'b0; #1;
        tests_run += 3;
        if (TX_D_VLD !== 1'b0)   begin tests_failed++; $display("FAIL midrst_tx_vld: got %b, want 0", TX_D_VLD); end
        if (CMD_RDY !== 1'b1)    begin tests_failed++; $display("FAIL midrst_cmd_rdy: got %b, want 1", CMD_RDY); end
        if (TX_P_DATA !== 8'h00) begin tests_failed++; $display("FAIL midrst_tx_data: got %h, want 00", TX_P_DATA); end
        repeat (2) begin @(posedge CLK_IN); #1; end
        RST_IN = 1'b1; TX_BUSY = 1'b0;
        repeat (10) begin @(posedge CLK_IN); #1; end
        tests_run += 2;
        if (rsp_log.size() != r0) begin tests_failed++; $display("FAIL midrst_rsp: %0d pulses, want 0", rsp_log.size() - r0); end
        if (tx_log.size() != n0)  begin tests_failed++; $display("FAIL midrst_tx: %0d bytes, want 0", tx_log.size() - n0); end
        test_reg_wr();
    endtask

    task automatic test_random();
        logic [1:0] t;
        int r, mode, k, nrsp;
        for (int n = 0; n < 40; n++) begin
            t = 2'($urandom);
            nrsp = (t == 2'd0) ? 0 : (t == 2'd1) ? 1 : 2;
            r = $urandom_range(9);
            mode = (r < 6) ? 0 : (r < 8) ? 1 : 2;
            k = (nrsp == 0) ? 0 : $urandom_range(nrsp - 1);
            if ($urandom_range(3) == 0) begin
                RX_D_VLD = 1'b1; RX_P_DATA = 8'($urandom); RX_ERR = 1'($urandom);
                @(posedge CLK_IN); #1; RX_D_VLD = 1'b0; RX_ERR = 1'b0;
            end
            do_txn(t, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                   8'($urandom), 8'($urandom), $urandom_range(60), mode, k, -1, 1'($urandom));
        end
        tests_run += 2;
        if (hold_viol != 0) begin tests_failed++; $display("FAIL tx_hold_random: %0d unstable stall cycles, want 0", hold_viol); end
        if (qual_viol != 0) begin tests_failed++; $display("FAIL flag_qualify: %0d flags outside RSP_VLD, want 0", qual_viol); end
    endtask

    initial begin
        test_reset();
        test_reg_wr();
        test_reg_rd();
        test_alu_op();
        test_busy_hold();
        test_timeout();
        test_rx_err_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "bench did not finish");
    end

endmodule
